// File: rtl/m5_pkg.sv
// Shared types for the m5 AR-snoop queue: the captured AR sample entry
// and the drain-side FSM state encoding.
package m5_pkg;

  localparam int M5_PAGE_SHIFT = 12;

  // One AR-channel sample as pushed by the capture side (36 bits).
  typedef struct packed {
    logic [33:0] araddr;
    logic        arvalid;
    logic        arready;
  } queue_struct_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } m5_drain_state_t;

endpackage

// File: rtl/m5_coalesce_window.sv
// Remembers the most recently emitted page and keeps it suppressed for a
// fixed number of cycles after each emit.
module m5_coalesce_window #(
  parameter int PG_W   = 22,
  parameter int WINDOW = 64,
  parameter int WIN_W  = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [PG_W-1:0] page,
  output logic            suppress
);

  logic [PG_W-1:0]  last_page;
  logic             last_valid;
  logic [WIN_W-1:0] win_cnt;

  assign suppress = last_valid && (last_page == page) && (win_cnt != '0);

  // A load beats a same-cycle flush so the new page becomes history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_page  <= '0;
      last_valid <= 1'b0;
      win_cnt    <= '0;
    end else if (load) begin
      last_page  <= page;
      last_valid <= 1'b1;
      win_cnt    <= WIN_W'(WINDOW);
    end else if (flush) begin
      last_valid <= 1'b0;
      win_cnt    <= '0;
    end else if (win_cnt != '0) begin
      win_cnt <= win_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/m5_ar_queue_drain.sv
// Pops AR-snoop entries, drops non-handshake samples and recently seen
// pages, and streams page numbers to the hot-page tracker.
module m5_ar_queue_drain
  import m5_pkg::*;
#(
  parameter int PAGE_SHIFT      = M5_PAGE_SHIFT,
  parameter int COALESCE_WINDOW = 64,
  parameter int CNT_W           = 32
) (
  input  logic                   axi4_mm_clk,
  input  logic                   axi4_mm_rst_n,
  input  logic                   q_empty,
  output logic                   q_rdreq,
  input  logic [35:0]            q_data,
  input  logic                   flush,
  output logic                   pg_valid,
  output logic [33-PAGE_SHIFT:0] pg_addr,
  input  logic                   pg_ready,
  output logic [CNT_W-1:0]       emit_cnt,
  output logic [CNT_W-1:0]       coal_cnt,
  output logic [CNT_W-1:0]       nohs_cnt,
  output logic [1:0]             fsm_state
);

  localparam int PG_W  = 34 - PAGE_SHIFT;
  localparam int WIN_W = (COALESCE_WINDOW > 0) ? $clog2(COALESCE_WINDOW + 1) : 1;

  // Stream handshake: pg_addr is held stable while pg_valid is high and
  // pg_ready is low; a transfer happens on any edge with both high.

  m5_drain_state_t state, state_nxt;
  queue_struct_t   entry;
  logic            hs;
  logic [PG_W-1:0] cand;
  logic            suppress;
  logic            load;
  logic            accept;
  logic            rdreq_raw;
  logic            unused_offset;

  assign entry         = q_data;
  assign hs            = entry.arvalid & entry.arready;
  assign cand          = entry.araddr[33:PAGE_SHIFT];
  assign unused_offset = ^entry.araddr[PAGE_SHIFT-1:0];
  assign load          = (state == S_WAIT) && hs && !suppress;
  assign accept        = (state == S_OUT) && pg_ready;
  assign fsm_state     = state;

  m5_coalesce_window #(
    .PG_W   (PG_W),
    .WINDOW (COALESCE_WINDOW),
    .WIN_W  (WIN_W)
  ) u_window (
    .clk      (axi4_mm_clk),
    .rst_n    (axi4_mm_rst_n),
    .flush    (flush),
    .load     (load),
    .page     (cand),
    .suppress (suppress)
  );

  always_comb begin
    state_nxt = state;
    rdreq_raw = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          rdreq_raw = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: state_nxt = load ? S_OUT : S_IDLE;
      S_OUT: begin
        if (pg_ready) begin
          if (!q_empty) begin
            rdreq_raw = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // No pop may be issued while reset is held, whatever the FIFO reports.
  assign q_rdreq = rdreq_raw & axi4_mm_rst_n;

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      state    <= S_IDLE;
      pg_valid <= 1'b0;
      pg_addr  <= '0;
      emit_cnt <= '0;
      coal_cnt <= '0;
      nohs_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        pg_valid <= 1'b1;
        pg_addr  <= cand;
      end else if (accept) begin
        pg_valid <= 1'b0;
      end
      if (accept && (emit_cnt != {CNT_W{1'b1}}))
        emit_cnt <= emit_cnt + 1'b1;
      if ((state == S_WAIT) && hs && suppress && (coal_cnt != {CNT_W{1'b1}}))
        coal_cnt <= coal_cnt + 1'b1;
      if ((state == S_WAIT) && !hs && (nohs_cnt != {CNT_W{1'b1}}))
        nohs_cnt <= nohs_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_m5_ar_queue_drain.sv
// Directed bench for m5_ar_queue_drain with a latency-1 FIFO model and an
// expected-page scoreboard checked on every downstream transfer.
module tb_m5_ar_queue_drain;
  import m5_pkg::*;

  localparam int PAGE_SHIFT = 12;
  localparam int WIN        = 64;
  localparam int CNT_W      = 32;
  localparam int PG_W       = 34 - PAGE_SHIFT;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              q_empty  = 1'b1;
  logic              q_rdreq;
  logic [35:0]       q_data   = '0;
  logic              flush    = 1'b0;
  logic              pg_valid;
  logic [PG_W-1:0]   pg_addr;
  logic              pg_ready = 1'b0;
  logic [CNT_W-1:0]  emit_cnt, coal_cnt, nohs_cnt;
  logic [1:0]        fsm_state;

  logic [35:0]       fifo[$];
  logic [PG_W-1:0]   exp_q[$];
  int                emit_cyc[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  bit                pop_pend = 1'b0;
  bit                rd_bad   = 1'b0;
  int                e_emit, e_nohs;
  logic [PG_W-1:0]   first_pg;
  logic [33:0]       addr;
  logic              av, ar;

  m5_ar_queue_drain #(
    .PAGE_SHIFT      (PAGE_SHIFT),
    .COALESCE_WINDOW (WIN),
    .CNT_W           (CNT_W)
  ) dut (
    .axi4_mm_clk   (clk),
    .axi4_mm_rst_n (rst_n),
    .q_empty       (q_empty),
    .q_rdreq       (q_rdreq),
    .q_data        (q_data),
    .flush         (flush),
    .pg_valid      (pg_valid),
    .pg_addr       (pg_addr),
    .pg_ready      (pg_ready),
    .emit_cnt      (emit_cnt),
    .coal_cnt      (coal_cnt),
    .nohs_cnt      (nohs_cnt),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, then model the FIFO read at posedge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst_n && pg_valid && pg_ready) begin
        emit_cyc.push_back(cyc);
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_emit observed=%0h expected=none", pg_addr);
        end
        if (exp_q.size() != 0) chk("pg_addr", pg_addr, exp_q.pop_front());
      end
      pop_pend = q_rdreq;
      if (q_rdreq && q_empty) rd_bad = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      if (pop_pend) begin
        if (fifo.size() != 0) q_data = fifo.pop_front();
        else rd_bad = 1'b1;
        q_empty = (fifo.size() == 0);
      end
    end
  endtask

  task automatic push(input logic [33:0] a, input logic v, input logic r, input bit expect_emit);
    fifo.push_back({a, v, r});
    q_empty = 1'b0;
    if (expect_emit) exp_q.push_back(a[33:PAGE_SHIFT]);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!pg_valid && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || fsm_state != S_IDLE) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_pg_valid", pg_valid, 0);
    chk("rst_pg_addr", pg_addr, 0);
    chk("rst_rdreq", q_rdreq, 0);
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_emit", emit_cnt, 0);

    // Reset while stalled in S_OUT abandons the popped entry.
    push(34'h0_0000_1000, 1'b1, 1'b1, 1'b0);
    wait_valid(10, "reach_out");
    chk("pre_rst_state", fsm_state, S_OUT);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_pg_valid", pg_valid, 0);
    chk("mid_rst_rdreq", q_rdreq, 0);
    chk("mid_rst_state", fsm_state, S_IDLE);
    chk("mid_rst_cnts", {emit_cnt | coal_cnt | nohs_cnt}, 0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_valid", pg_valid, 0);

    pg_ready = 1'b1;
    push(34'h0_0001_2345, 1'b1, 1'b1, 1'b1);
    wait_idle(20, "t1_drain");
    chk("t1_emit", emit_cnt, 1);
    chk("t1_valid_low", pg_valid, 0);
    chk("t1_once", emit_cyc.size(), 1);

    push(34'h5000, 1'b1, 1'b0, 1'b0);
    wait_idle(20, "t2_drain");
    push(34'h6000, 1'b0, 1'b1, 1'b0);
    wait_idle(20, "t2b_drain");
    chk("t2_nohs", nohs_cnt, 2);
    chk("t2_emit", emit_cnt, 1);

    push(34'h7000, 1'b1, 1'b1, 1'b1);
    tick(3);
    push(34'h7FF8, 1'b1, 1'b1, 1'b0);
    wait_idle(20, "t3_drain");
    chk("t3_coal", coal_cnt, 1);
    chk("t3_emit", emit_cnt, 2);

    tick(70);
    push(34'h7000, 1'b1, 1'b1, 1'b1);
    tick(70);
    push(34'h7FF8, 1'b1, 1'b1, 1'b1);
    wait_idle(20, "t3b_drain");
    chk("t3b_emit", emit_cnt, 4);
    chk("t3b_coal", coal_cnt, 1);

    tick(70);
    push(34'h7000, 1'b1, 1'b1, 1'b1);
    wait_idle(20, "t4a_drain");
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    push(34'h7FF8, 1'b1, 1'b1, 1'b1);
    wait_idle(20, "t4_drain");
    chk("t4_emit", emit_cnt, 6);
    chk("t4_coal", coal_cnt, 1);

    // Flush on the same edge as a load: the loaded page must stay history.
    push(34'h9000, 1'b1, 1'b1, 1'b1);
    tick(1);
    chk("fc_wait", fsm_state, S_WAIT);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fc_out", fsm_state, S_OUT);
    push(34'h9ABC, 1'b1, 1'b1, 1'b0);
    wait_idle(20, "fc_drain");
    chk("fc_coal", coal_cnt, 2);
    chk("fc_emit", emit_cnt, 7);

    pg_ready = 1'b0;
    emit_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      addr = {22'(32'h100 + i), 12'($urandom_range(0, 4095))};
      push(addr, 1'b1, 1'b1, 1'b1);
    end
    wait_valid(10, "t6_first_valid");
    first_pg = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", pg_valid, 1);
      chk("stall_addr", pg_addr, first_pg);
      tick(1);
    end
    chk("stall_no_pop", q_rdreq, 0);
    pg_ready = 1'b1;
    wait_idle(60, "t6_drain");
    chk("t6_count", emit_cyc.size(), 8);
    for (int i = 1; i < 8; i++)
      if (i < emit_cyc.size()) chk("t6_gap", emit_cyc[i] - emit_cyc[i-1], 2);
    chk("t6_emit", emit_cnt, 15);

    e_emit = 15;
    e_nohs = 2;
    for (int i = 0; i < 6; i++) begin
      av = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      addr = {22'(32'h200 + i), 12'($urandom_range(0, 4095))};
      push(addr, av, ar, av & ar);
      if (av & ar) e_emit++;
      else e_nohs++;
    end
    wait_idle(60, "t7_drain");
    chk("t7_emit", emit_cnt, e_emit);
    chk("t7_nohs", nohs_cnt, e_nohs);
    chk("t7_coal", coal_cnt, 2);

    chk("rdreq_when_empty", rd_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
